// File: rtl/single_min_reduce.sv
// rtl/single_min_reduce.sv - streaming float32 packet minimum around a pipelined single_min.
// Optional out_index port and position tracking enabled by SINGLE_MIN_REDUCE_INDEX_EN.

// Float32 minimum. z is valid in the LATENCY-th cycle counting the cycle in which a/b change,
// i.e. LATENCY-1 register stages. A single NaN loses to a number; two NaNs or equal bits return a; -0 < +0.
module single_min #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z
);
  localparam int STAGES = LATENCY - 1;

  logic        a_nan;
  logic        b_nan;
  logic [31:0] a_key;
  logic [31:0] b_key;
  logic        pick_b;
  logic [31:0] min_c;
  logic [31:0] pipe [STAGES];

  assign a_nan = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
  assign b_nan = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);

  // Map sign-magnitude onto an unsigned order so one comparator covers every sign case.
  assign a_key = a[31] ? ~a : {1'b1, a[30:0]};
  assign b_key = b[31] ? ~b : {1'b1, b[30:0]};

  assign pick_b = (a_nan && !b_nan) || (!a_nan && !b_nan && (b_key < a_key));
  assign min_c  = pick_b ? b : a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= 32'd0;
    end else begin
      pipe[0] <= min_c;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign z = pipe[STAGES-1];
endmodule

module single_min_reduce #(
  parameter int MIN_LATENCY = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [31:0]            out_data,
  output logic [COUNT_WIDTH-1:0] out_count,
`ifdef SINGLE_MIN_REDUCE_INDEX_EN
  output logic [COUNT_WIDTH-1:0] out_index,
`endif
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int BUSY_W = $clog2(MIN_LATENCY + 1);

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    NEXT  = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [31:0]            acc;
  logic [31:0]            op_b;
  logic                   last_q;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [BUSY_W-1:0]      busy_cnt;
  logic [31:0]            z;
  logic                   accept;
  logic                   busy_end;
`ifdef SINGLE_MIN_REDUCE_INDEX_EN
  logic [COUNT_WIDTH-1:0] idx;
`endif

  single_min #(
    .LATENCY(MIN_LATENCY)
  ) u_min (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (acc),
    .b    (op_b),
    .z    (z)
  );

  assign accept   = in_valid && in_ready;
  assign busy_end = (state == BUSY) && (busy_cnt == BUSY_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FIRST;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      FIRST: begin
        in_ready = 1'b1;
        if (in_valid) state_next = in_last ? DONE : NEXT;
      end
      NEXT: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (busy_cnt == BUSY_W'(1)) state_next = last_q ? DONE : NEXT;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = FIRST;
      end
      default: state_next = FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= 32'd0;
      op_b     <= 32'd0;
      last_q   <= 1'b0;
      cnt      <= '0;
      busy_cnt <= '0;
    end else begin
      if (accept && state == FIRST) begin
        acc <= in_data;
        cnt <= COUNT_WIDTH'(1);
      end
      if (accept && state == NEXT) begin
        op_b     <= in_data;
        last_q   <= in_last;
        cnt      <= cnt + COUNT_WIDTH'(1);
        busy_cnt <= BUSY_W'(MIN_LATENCY);
      end
      if (state == BUSY) begin
        busy_cnt <= busy_cnt - BUSY_W'(1);
        if (busy_end) acc <= z;
      end
    end
  end

`ifdef SINGLE_MIN_REDUCE_INDEX_EN
  // The new element won only if z took op_b's bits and not acc's; equal bits keep the earlier position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (accept && state == FIRST) begin
      idx <= '0;
    end else if (busy_end && (z == op_b) && (z != acc)) begin
      idx <= cnt - COUNT_WIDTH'(1);
    end
  end

  assign out_index = idx;
`endif

  assign out_data  = acc;
  assign out_count = cnt;
endmodule

// File: tb/tb_single_min_reduce.sv
// tb/tb_single_min_reduce.sv - directed and random packets checked against a float-min reference.
module tb_single_min_reduce;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic [15:0] out_count;
  logic        out_valid;
  logic        out_ready;
`ifdef SINGLE_MIN_REDUCE_INDEX_EN
  logic [15:0] out_index;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] pkt[$];

  always #5 clk = ~clk;

  single_min_reduce #(
    .MIN_LATENCY(2),
    .COUNT_WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_count(out_count),
`ifdef SINGLE_MIN_REDUCE_INDEX_EN
    .out_index(out_index),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hff) && (x[22:0] != 0);
  endfunction

  // Reference: smaller float wins; a lone NaN loses; two NaNs or a tie keep a; -0 beats +0.
  function automatic logic [31:0] ref_min(input logic [31:0] a, input logic [31:0] b);
    int unsigned ma, mb;
    if (is_nan(a) && is_nan(b)) return a;
    if (is_nan(a)) return b;
    if (is_nan(b)) return a;
    ma = a[30:0];
    mb = b[30:0];
    if (a[31] != b[31]) return a[31] ? a : b;
    if (!a[31]) return (mb < ma) ? b : a;
    return (mb > ma) ? b : a;
  endfunction

  // Starts and ends at a negedge; each element waits a bounded time for in_ready.
  task automatic send_pkt(input string tag);
    for (int i = 0; i < pkt.size(); i++) begin
      int w = 0;
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = (i == pkt.size() - 1);
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w >= 20) chk({tag, "_ready_timeout"}, 32'(w), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic collect(input string tag, input int hold);
    logic [31:0] exp_min, nxt;
    int exp_idx, w;
    exp_min = pkt[0];
    exp_idx = 0;
    for (int i = 1; i < pkt.size(); i++) begin
      nxt = ref_min(exp_min, pkt[i]);
      if (nxt !== exp_min) exp_idx = i;
      exp_min = nxt;
    end
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, exp_min);
    chk({tag, "_count"}, 32'(out_count), 32'(pkt.size()));
`ifdef SINGLE_MIN_REDUCE_INDEX_EN
    chk({tag, "_index"}, 32'(out_index), 32'(exp_idx));
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_data"}, out_data, exp_min);
      chk({tag, "_hold_count"}, 32'(out_count), 32'(pkt.size()));
      chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_after_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_after_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int exp_pat[8];
    int k;
    rst_n     = 1'b0;
    in_data   = 32'd0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SINGLE_MIN_REDUCE_INDEX_EN
    chk("rst_out_index", 32'(out_index), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    pkt = '{32'h40400000, 32'h3F800000, 32'h40000000};
    send_pkt("three");
    collect("three", 0);

    pkt = '{32'hBF000000};
    send_pkt("single");
    chk("single_valid_next_cycle", 32'(out_valid), 32'd1);
    collect("single", 0);

    // in_valid held high: one accept per three cycles after the first element.
    exp_pat = '{1, 1, 0, 0, 1, 0, 0, 1};
    pkt = '{32'h40400000, 32'h3F800000, 32'h40000000, 32'h3F000000};
    k = 0;
    in_valid = 1'b1;
    in_data  = pkt[0];
    in_last  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("ready_pattern", 32'(in_ready), 32'(exp_pat[c]));
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        k++;
        if (k < 4) begin
          in_data = pkt[k];
          in_last = (k == 3);
        end else begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
    chk("ready_pattern_accepts", 32'(k), 32'd4);
    in_valid = 1'b0;
    collect("stream", 10);

    pkt = '{32'h3F800000, 32'h3F800000};
    send_pkt("tie");
    collect("tie", 0);

    pkt = '{32'h00000000, 32'h80000000, 32'h7FC00000};
    send_pkt("zeros");
    collect("zeros", 1);

    // Reset while the second element is in flight.
    pkt = '{32'h3F800000, 32'h3F000000};
    send_pkt("abort");
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rst_valid", 32'(out_valid), 32'd0);
    chk("abort_rst_ready", 32'(in_ready), 32'd1);
    chk("abort_rst_data", out_data, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_output", 32'(out_valid), 32'd0);
    pkt = '{32'h40000000};
    send_pkt("after_abort");
    collect("after_abort", 0);

    for (int p = 0; p < 10; p++) begin
      int n = $urandom_range(1, 7);
      pkt = {};
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 9))
          0:       pkt.push_back(32'h00000000);
          1:       pkt.push_back(32'h80000000);
          2:       pkt.push_back(32'h7FC00000);
          3:       pkt.push_back(32'h3F800000);
          default: pkt.push_back($urandom);
        endcase
      end
      send_pkt("rand");
      collect("rand", $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
